// File: rtl/mdio_slave_ctrl_if.sv
// mdio_slave_ctrl_if: MDIO pad signals and register-file strobes of the MDIO slave
interface mdio_slave_ctrl_if;
  logic        mdc;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oen;
  logic [4:0]  reg_addr;
  logic        reg_wr;
  logic [15:0] reg_wdata;
  logic        reg_rd;
  logic [15:0] reg_rdata;
  logic        frame_err;
  modport slave (input mdc, mdio_in, reg_rdata,
                 output mdio_out, mdio_oen, reg_addr, reg_wr, reg_wdata, reg_rd, frame_err);
  modport master (output mdc, mdio_in, reg_rdata,
                  input mdio_out, mdio_oen, reg_addr, reg_wr, reg_wdata, reg_rd, frame_err);
endinterface

// File: rtl/mdio_slave_ctrl.sv
// mdio_slave_ctrl: Clause-22 MDIO slave turning oversampled frames into register strobes.
// Define MDIO_PREAMBLE_SUPPRESS_EN to accept ST after a single preamble 1 instead of 32.
module mdio_slave_ctrl #(
  parameter logic [4:0] PHY_ADDR    = 5'd1,
  parameter int         SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst_n,
  mdio_slave_ctrl_if.slave bus
);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam logic [5:0] PRE_THR = 6'd1;
`else
  localparam logic [5:0] PRE_THR = 6'd32;
`endif
  typedef enum logic [3:0] {IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA, SKIP} state_t;
  state_t                 r_state, w_state;
  logic [SYNC_STAGES-1:0] r_mdc_sync, r_mdio_sync;
  logic                   r_mdc_d, r_ld;
  logic [5:0]             r_pre, w_pre;
  logic [4:0]             r_cnt, w_cnt, r_phy, w_phy, r_addr, w_addr;
  logic [15:0]            r_sh, w_sh, r_wdata, w_wdata;
  logic                   r_rd_op, w_rd_op;
  logic                   r_oen, w_oen, r_out, w_out;
  logic                   r_wr, w_wr, r_rd, w_rd, r_err, w_err;
  logic                   w_mdc, w_mdio, w_rise, w_fall;
  logic [15:0]            w_shin;
  assign w_mdc  = r_mdc_sync[SYNC_STAGES-1];
  assign w_mdio = r_mdio_sync[SYNC_STAGES-1];
  assign w_rise = w_mdc & ~r_mdc_d;
  assign w_fall = ~w_mdc & r_mdc_d;
  assign w_shin = {r_sh[14:0], w_mdio};
  assign bus.mdio_out  = r_out;
  assign bus.mdio_oen  = r_oen;
  assign bus.reg_addr  = r_addr;
  assign bus.reg_wr    = r_wr;
  assign bus.reg_wdata = r_wdata;
  assign bus.reg_rd    = r_rd;
  assign bus.frame_err = r_err;
  // Synchronisers, edge history and all frame state; reset releases the pad immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mdc_sync  <= '0;
      r_mdio_sync <= '0;
      r_mdc_d     <= 1'b0;
      r_ld        <= 1'b0;
      r_state     <= IDLE;
      r_pre       <= '0;
      r_cnt       <= '0;
      r_phy       <= '0;
      r_addr      <= '0;
      r_sh        <= '0;
      r_wdata     <= '0;
      r_rd_op     <= 1'b0;
      r_oen       <= 1'b1;
      r_out       <= 1'b0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mdc_sync  <= {r_mdc_sync[SYNC_STAGES-2:0], bus.mdc};
      r_mdio_sync <= {r_mdio_sync[SYNC_STAGES-2:0], bus.mdio_in};
      r_mdc_d     <= w_mdc;
      r_ld        <= r_rd;
      r_state     <= w_state;
      r_pre       <= w_pre;
      r_cnt       <= w_cnt;
      r_phy       <= w_phy;
      r_addr      <= w_addr;
      r_sh        <= w_sh;
      r_wdata     <= w_wdata;
      r_rd_op     <= w_rd_op;
      r_oen       <= w_oen;
      r_out       <= w_out;
      r_wr        <= w_wr;
      r_rd        <= w_rd;
      r_err       <= w_err;
    end
  end
  // Frame decoder: fields are sampled on MDC rises, read turnaround/data driven on falls
  always_comb begin
    w_state = r_state;
    w_pre   = r_pre;
    w_cnt   = r_cnt;
    w_phy   = r_phy;
    w_addr  = r_addr;
    w_sh    = r_sh;
    w_wdata = r_wdata;
    w_rd_op = r_rd_op;
    w_oen   = r_oen;
    w_out   = r_out;
    w_wr    = 1'b0;
    w_rd    = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      IDLE: if (w_rise) begin
        w_pre = w_mdio ? (r_pre == 6'd32 ? r_pre : r_pre + 6'd1) : 6'd0;
        if (!w_mdio && r_pre >= PRE_THR) w_state = ST;
      end
      ST: if (w_rise) begin
        w_state = w_mdio ? OP : IDLE;
        w_err   = !w_mdio;
        w_cnt   = 5'd0;
      end
      OP: if (w_rise) begin
        w_sh  = w_shin;
        w_cnt = r_cnt + 5'd1;
        if (r_cnt == 5'd1) begin
          w_rd_op = r_sh[0];
          w_cnt   = 5'd0;
          w_state = (r_sh[0] ^ w_mdio) ? PHYAD : IDLE;
          w_err   = !(r_sh[0] ^ w_mdio);
        end
      end
      PHYAD: if (w_rise) begin
        w_sh  = w_shin;
        w_cnt = r_cnt + 5'd1;
        if (r_cnt == 5'd4) begin
          w_phy   = w_shin[4:0];
          w_cnt   = 5'd0;
          w_state = REGAD;
        end
      end
      REGAD: if (w_rise) begin
        w_sh  = w_shin;
        w_cnt = r_cnt + 5'd1;
        if (r_cnt == 5'd4) begin
          w_addr  = w_shin[4:0];
          w_cnt   = r_phy == PHY_ADDR ? 5'd0 : 5'd18;
          w_state = r_phy == PHY_ADDR ? TA : SKIP;
          w_rd    = r_phy == PHY_ADDR && r_rd_op;
        end
      end
      TA: if (r_rd_op) begin
        if (w_fall) begin
          w_cnt   = 5'd1;
          w_oen   = r_cnt == 5'd0;
          w_out   = 1'b0;
          w_state = r_cnt == 5'd0 ? TA : RDATA;
          if (r_cnt != 5'd0) w_cnt = 5'd0;
        end
      end else if (w_rise) begin
        w_sh  = w_shin;
        w_cnt = r_cnt + 5'd1;
        if (r_cnt == 5'd1) begin
          w_err   = {r_sh[0], w_mdio} != 2'b10;
          w_cnt   = {r_sh[0], w_mdio} == 2'b10 ? 5'd0 : 5'd16;
          w_state = {r_sh[0], w_mdio} == 2'b10 ? WDATA : SKIP;
        end
      end
      WDATA: if (w_rise) begin
        w_sh  = w_shin;
        w_cnt = r_cnt + 5'd1;
        if (r_cnt == 5'd15) begin
          w_wdata = w_shin;
          w_wr    = 1'b1;
          w_state = IDLE;
        end
      end
      RDATA: if (w_fall) begin
        w_oen   = r_cnt == 5'd16;
        w_out   = r_cnt == 5'd16 ? 1'b0 : r_sh[15];
        w_sh    = {r_sh[14:0], 1'b0};
        w_cnt   = r_cnt + 5'd1;
        w_state = r_cnt == 5'd16 ? IDLE : RDATA;
      end
      SKIP: if (w_rise) begin
        w_cnt   = r_cnt - 5'd1;
        w_state = r_cnt == 5'd1 ? IDLE : SKIP;
      end
      default: w_state = IDLE;
    endcase
    if (r_ld) w_sh = bus.reg_rdata;
  end
endmodule

// File: doc/mdio_slave_ctrl.md
# mdio_slave_ctrl

- Clause-22 MDIO slave controller for the ADC capture chip's management port.
- Oversamples the MDC and MDIO pad inputs in the system clock domain and decodes read/write frames.
- Drives the MDIO pad's data input and active-low output enable for read turnaround and read data.
- Converts frames into single-cycle register strobes towards the configuration register file.
- Sits between the pad ring (MDC/MDIO pads) and the capture-config registers.

## Interface
- PHY_ADDR, 5'd1, PHYAD value this slave answers to.
- SYNC_STAGES, 2, synchroniser depth for MDC and MDIO (≥2).
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset; release is synchronised externally.
- mdc  input  1  MDC from pad, asynchronous to clk.
- mdio_in  input  1  MDIO value from pad receiver.
- mdio_out  output  1  data to MDIO pad driver input.
- mdio_oen  output  1  pad output enable, active low: 0 = drive, 1 = release.
- reg_addr  output  5  register address (REGAD), held until next frame.
- reg_wr  output  1  one-cycle write strobe.
- reg_wdata  output  16  write data, valid with reg_wr and held after.
- reg_rd  output  1  one-cycle read strobe.
- reg_rdata  input  16  read data; must be valid the clk after reg_rd.
- frame_err  output  1  one-cycle pulse on malformed frame.

## Operation
- mdc and mdio_in each pass through SYNC_STAGES flops.
- A rising edge of synced mdc (rise) samples synced mdio; a falling edge (fall) updates the outputs.
- States: IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA, SKIP. A 5-bit counter indexes bits within a field.
- IDLE:
  - Counts consecutive sampled 1s, saturating at 32.
  - A 0 with count=32 is ST bit 1; go to ST.
  - A 0 with count<32 clears the count, with no error.
- ST: expects 1; a 0 gives frame_err and returns to IDLE.
- OP: 2 bits.
  - 10 = read; 01 = write.
  - 00 or 11 gives frame_err and returns to IDLE.
- PHYAD: 5 bits MSB first.
- REGAD: 5 bits MSB first.
  - On the last bit, reg_addr updates.
  - PHYAD≠PHY_ADDR goes to SKIP.
  - Read with match: reg_rd pulses and reg_rdata is latched into a shift register the next clk.
- TA:
  - Write: expects sampled 10; otherwise frame_err and go to SKIP.
  - Read, first TA bit: the fall after the last REGAD bit keeps mdio_oen=1.
  - Read, second TA bit: the next fall sets mdio_oen=0, mdio_out=0.
- RDATA:
  - Each following fall drives the next data bit, MSB first, for 16 bits.
  - The fall after bit 0's period sets mdio_oen=1 and mdio_out=0, then IDLE.
- WDATA:
  - 16 rises shift data in, MSB first.
  - After the last rise, reg_wdata loads and reg_wr pulses; then IDLE.
- SKIP: counts the remaining TA+data bits (18 minus those consumed), never drives, then IDLE.
- Preamble count clears on every exit to IDLE; each frame needs its own preamble (unless suppressed).
- Reset values: mdio_oen=1, mdio_out=0, reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0, frame_err=0, state IDLE, preamble count 0.
- Reset asserted mid-frame releases the pad (mdio_oen=1) immediately and asynchronously.

## Timing
- Supported MDC: high and low phases each ≥3 clk; period ≥8 clk.
- Edge detect latency: SYNC_STAGES+1 clk after the pad edge.
- mdio_oen and mdio_out change 1 clk after the fall is detected.
- reg_rd: 1 clk after the last REGAD rise is detected; reg_rdata is sampled on the following clk.
  - This is well before the first data fall.
- reg_wr: 1 clk after the last WDATA rise is detected.
- reg_wr and reg_rd are never asserted together; at most one strobe per frame.
- A simultaneous rise and fall cannot occur (edge detect on one synced signal).

## Configuration
- MDIO_PREAMBLE_SUPPRESS_EN defined: IDLE accepts ST after a single sampled 1; count threshold 1 instead of 32.
- Undefined: the full 32-bit preamble is required.

## Test plan
- Write: 32×1 preamble, ST=01, OP=01, PHYAD=1, REGAD=0x05, TA=10, data 0xA5C3 -> exactly one reg_wr, reg_addr=5, reg_wdata=0xA5C3, mdio_oen=1 throughout.
- Read: REGAD=0x02, reg_rdata=0x1234 -> one reg_rd; pad sees Z, 0, then 0x1234 MSB first on falls, then release; no reg_wr.
- PHYAD=3 write and read frames -> no strobes, mdio_oen stays 1, no frame_err, next valid frame decoded.
- 31-bit preamble then frame -> ignored, no strobe; OP=11 after full preamble -> one frame_err pulse, return to IDLE.
- rst_n low in the middle of read data -> mdio_oen=1 asynchronously, all outputs at reset values; a following valid read works.
- Macro defined: one preamble 1 then a write frame -> reg_wr fires. Macro undefined: the same stimulus produces no strobe.
